// File: rtl/muldiv_seq.sv
// Sequential multiply/divide unit with HI/LO result register.
// One radix-2 step per clock: shift-add multiply, restoring divide, 32 iterations each.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk_cpu,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     src_rs,
  input  logic [WIDTH-1:0]     src_rt,
  input  logic                 flush,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero,
  output logic [2*WIDTH-1:0]   hilo_q
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;
  logic               isdiv_q, isdiv_d;
  logic [2*WIDTH-1:0] hilo_d;
  logic               done_d, dbz_d;

  // Operand magnitudes and signs; only mult/div treat operands as signed.
  logic             sgn_op, rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;

  assign sgn_op = (op == 3'd0) || (op == 3'd2);
  assign rs_neg = sgn_op & src_rs[WIDTH-1];
  assign rt_neg = sgn_op & src_rt[WIDTH-1];
  assign rs_mag = rs_neg ? -src_rs : src_rs;
  assign rt_mag = rt_neg ? -src_rt : src_rt;

  // p_q holds {partial product, remaining multiplier bits} during MUL.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : '0);
  assign mul_next = {mul_sum, p_q[WIDTH-1:1]};

  // p_q holds {remainder, dividend bits shifting into quotient} during DIV.
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;

  assign div_sh   = p_q[2*WIDTH-1:WIDTH-1];
  assign div_ge   = div_sh >= {1'b0, a_q};
  assign div_rem  = div_ge ? (div_sh[WIDTH-1:0] - a_q) : div_sh[WIDTH-1:0];
  assign div_next = {div_rem, p_q[WIDTH-2:0], div_ge};

  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   quo_s, rem_s;

  assign mul_res = neg_q  ? -p_q : p_q;
  assign quo_s   = neg_q  ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
  assign rem_s   = rneg_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    p_d     = p_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    isdiv_d = isdiv_q;
    hilo_d  = hilo_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    if (flush && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !flush) begin
            case (op)
              3'd0, 3'd1: begin
                state_d = S_MUL;
                cnt_d   = '0;
                a_d     = rs_mag;
                p_d     = {{WIDTH{1'b0}}, rt_mag};
                neg_d   = rs_neg ^ rt_neg;
                rneg_d  = 1'b0;
                dz_d    = 1'b0;
                isdiv_d = 1'b0;
              end
              3'd2, 3'd3: begin
                state_d = S_DIV;
                cnt_d   = '0;
                a_d     = rt_mag;
                p_d     = {{WIDTH{1'b0}}, rs_mag};
                neg_d   = rs_neg ^ rt_neg;
                rneg_d  = rs_neg;
                dz_d    = (src_rt == '0);
                isdiv_d = 1'b1;
              end
              3'd4:    hilo_d[2*WIDTH-1:WIDTH] = src_rs;
              3'd5:    hilo_d[WIDTH-1:0]       = src_rs;
              default: ;
            endcase
          end
        end
        S_MUL, S_DIV: begin
          p_d   = (state_q == S_MUL) ? mul_next : div_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH-1)) state_d = S_FIN;
        end
        S_FIN: begin
          // A zero divisor still yields HI = src_rs naturally; only LO is forced.
          if (isdiv_q) hilo_d = {rem_s, dz_q ? {WIDTH{1'b1}} : quo_s};
          else         hilo_d = mul_res;
          done_d  = 1'b1;
          dbz_d   = isdiv_q & dz_q;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_cpu or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      p_q         <= '0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      dz_q        <= 1'b0;
      isdiv_q     <= 1'b0;
      hilo_q      <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      p_q         <= p_d;
      neg_q       <= neg_d;
      rneg_q      <= rneg_d;
      dz_q        <= dz_d;
      isdiv_q     <= isdiv_d;
      hilo_q      <= hilo_d;
      done        <= done_d;
      div_by_zero <= dbz_d;
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter: WIDTH, 32, operand width; HI/LO total 2*WIDTH; only 32 is supported.
REQ-002 clk_cpu  input  1  CPU clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  operation request, sampled only in IDLE.
REQ-005 op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6-7 reserved.
REQ-006 src_rs  input  32  first operand / mthi-mtlo source.
REQ-007 src_rt  input  32  second operand.
REQ-008 flush  input  1  abort the in-flight operation (pipeline redirect).
REQ-009 busy  output  1  high while an iterative operation occupies the unit; pipeline stalls on it.
REQ-010 done  output  1  one-cycle pulse when HI/LO has been written by mult/multu/div/divu.
REQ-011 div_by_zero  output  1  high only in the done cycle of a div/divu with src_rt == 0.
REQ-012 hilo_q  output  64  {HI, LO} register contents.

Function
REQ-013 States: IDLE, MUL, DIV, FIN; FSM is registered.
REQ-014 IDLE + start + op in {0,1}: latch operand magnitudes and result signs, clear iteration counter, go to MUL.
REQ-015 IDLE + start + op in {2,3}: latch operand magnitudes and result signs, clear counter, go to DIV.
REQ-016 IDLE + start + op 4: HI <= src_rs at that edge, LO unchanged, stay in IDLE, no busy, no done.
REQ-017 IDLE + start + op 5: LO <= src_rs at that edge, HI unchanged, stay in IDLE, no busy, no done.
REQ-018 start with op 6 or 7 is ignored; state and HI/LO unchanged.
REQ-019 start outside IDLE is ignored; no queuing.
REQ-020 MUL: radix-2 shift-add, one bit per cycle, exactly 32 iterations, then FIN.
REQ-021 DIV: radix-2 restoring division, one quotient bit per cycle, exactly 32 iterations, then FIN.
REQ-022 FIN: apply result signs, write HI/LO, pulse done for one cycle, return to IDLE.
REQ-023 Latency: start accepted at edge E0; busy high from E0 up to E33; HI/LO written and done high from E33; busy low from E33; start accepted again at E34.
REQ-024 mult: {HI,LO} = signed 64-bit product; multu: unsigned 64-bit product.
REQ-025 div/divu: LO = quotient, HI = remainder.
REQ-026 div signs: quotient negative iff operand signs differ; remainder takes the sign of src_rs; both truncate toward zero.
REQ-027 div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0; no overflow flag.
REQ-028 Divide by zero (div or divu): HI = src_rs, LO = 0xFFFFFFFF, div_by_zero = 1 in the done cycle, latency unchanged.
REQ-029 Operands are captured at the start edge; src_rs/src_rt changes afterwards have no effect.
REQ-030 flush in MUL/DIV/FIN: next state IDLE, HI/LO unchanged, no done, busy low after that edge.
REQ-031 flush in IDLE: no effect; flush and start in the same IDLE cycle: flush wins, start ignored.
REQ-032 hilo_q changes only at FIN, mthi, or mtlo.

Reset
REQ-033 When reset is low: state IDLE, hilo_q = 0, busy = 0, done = 0, div_by_zero = 0, counter = 0, immediately and independent of clk_cpu.
REQ-034 Reset asserted mid-operation discards it; no done pulse follows deassertion.

Verification
REQ-035 mult 0xFFFFFFFF x 0x00000002 -> 33 cycles busy, then hilo_q = 0xFFFFFFFF_FFFFFFFE, done for 1 cycle.
REQ-036 multu 0xFFFFFFFF x 0x00000002 -> hilo_q = 0x00000001_FFFFFFFE.
REQ-037 div -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; divu 7 / 0 -> HI = 7, LO = 0xFFFFFFFF, div_by_zero = 1.
REQ-038 mthi 0x12345678, then mtlo 0x9ABCDEF0 on consecutive cycles -> hilo_q = 0x12345678_9ABCDEF0, busy stays 0.
REQ-039 divu started, flush at iteration 10, start ignored while busy -> hilo_q unchanged, no done; a new mult is accepted on the next cycle.
REQ-040 reset driven low at iteration 20 of a mult -> all outputs 0 at once; no done after release.
